// File: rtl/udp_rmii_rx.sv
// Receive-side RMII MAC: assembles RXD dibits into bytes, filters Ethernet/IPv4/UDP headers
// against the local addresses, streams the UDP payload and checks the Ethernet FCS.
module udp_rmii_rx #(
    parameter logic [47:0] mac_my_adr   = 48'd0,
    parameter logic [31:0] ip_my_adr    = 32'd0,
    parameter logic [15:0] udp_my_port  = 16'd0,
    parameter bit          accept_bcast = 1'b1,
    parameter logic [15:0] max_frame    = 16'd1522
) (
    input  logic        I_clk50m,
    input  logic        I_rst,
    input  logic [1:0]  I_rxd,
    input  logic        I_crs_dv,
    output logic [7:0]  O_data,
    output logic        O_valid,
    output logic        O_sof,
    output logic        O_eof,
    output logic [15:0] O_udpLen,
    output logic        O_done,
    output logic        O_crc_ok,
    output logic        O_drop,
    output logic        O_busy
);
    typedef enum logic [3:0] {
        StIdle, StPreamble, StDstMac, StSrcMac, StEtype,
        StIpHdr, StUdpHdr, StPayload, StTail, StDrop
    } state_e;

    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    state_e      state_q;
    logic [1:0]  dib_cnt_q;
    logic [5:0]  shift_q;
    logic [7:0]  prev_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] pay_cnt_q;
    logic [31:0] crc_q;
    logic        uc_ok_q;
    logic        bc_ok_q;
    logic        armed_q;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CrcPoly : 32'd0);
        end
        return r;
    endfunction

    logic        in_frame;
    logic        dibit_en;
    logic        byte_en;
    logic        frame_end;
    logic        hdr_fail;
    logic        len_over;
    logic        uc_ok_d;
    logic        bc_ok_d;
    logic [7:0]  rx_byte;
    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic [15:0] hdr_word;
    logic [2:0]  mac_sel;
    logic [1:0]  ip_sel;

    always_comb begin
        in_frame  = state_q inside {StDstMac, StSrcMac, StEtype, StIpHdr, StUdpHdr,
                                    StPayload, StTail, StDrop};
        dibit_en  = in_frame && I_crs_dv;
        byte_en   = dibit_en && (dib_cnt_q == 2'd3);
        frame_end = in_frame && !I_crs_dv && (dib_cnt_q == 2'd0);
        rx_byte   = {I_rxd, shift_q};
        hdr_word  = {prev_q, rx_byte};
        mac_sel   = 3'd5 - frame_cnt_q[2:0];
        mac_byte  = 8'(mac_my_adr >> {mac_sel, 3'b000});
        // IP dst occupies frame bytes 30..33, most significant byte first
        ip_sel    = 2'd1 - frame_cnt_q[1:0];
        ip_byte   = 8'(ip_my_adr >> {ip_sel, 3'b000});
        uc_ok_d   = uc_ok_q && (rx_byte == mac_byte);
        bc_ok_d   = bc_ok_q && (rx_byte == 8'hFF);
        len_over  = frame_cnt_q >= max_frame;
        hdr_fail  = 1'b0;
        case (state_q)
            StDstMac: hdr_fail = !uc_ok_d && !bc_ok_d;
            StEtype:  hdr_fail = rx_byte != (frame_cnt_q[0] ? 8'h00 : 8'h08);
            StIpHdr: begin
                case (frame_cnt_q)
                    16'd14:                         hdr_fail = rx_byte != 8'h45;
                    16'd23:                         hdr_fail = rx_byte != 8'h11;
                    16'd30, 16'd31, 16'd32, 16'd33: hdr_fail = rx_byte != ip_byte;
                    default:                        hdr_fail = 1'b0;
                endcase
            end
            StUdpHdr: begin
                case (frame_cnt_q)
                    16'd37:  hdr_fail = hdr_word != udp_my_port;
                    16'd39:  hdr_fail = hdr_word < 16'd8;
                    default: hdr_fail = 1'b0;
                endcase
            end
            default: hdr_fail = 1'b0;
        endcase
    end

    always_ff @(posedge I_clk50m) begin
        if (I_rst) begin
            state_q     <= StIdle;
            dib_cnt_q   <= 2'd0;
            shift_q     <= 6'd0;
            prev_q      <= 8'd0;
            frame_cnt_q <= 16'd0;
            pay_cnt_q   <= 16'd0;
            crc_q       <= 32'hFFFFFFFF;
            uc_ok_q     <= 1'b0;
            bc_ok_q     <= 1'b0;
            armed_q     <= 1'b0;
            O_data      <= 8'd0;
            O_valid     <= 1'b0;
            O_sof       <= 1'b0;
            O_eof       <= 1'b0;
            O_udpLen    <= 16'd0;
            O_done      <= 1'b0;
            O_crc_ok    <= 1'b0;
            O_drop      <= 1'b0;
            O_busy      <= 1'b0;
        end else begin
            O_valid <= 1'b0;
            O_sof   <= 1'b0;
            O_eof   <= 1'b0;
            O_done  <= 1'b0;
            O_drop  <= 1'b0;
            // After reset, wait for a carrier gap so an aborted frame's tail cannot fake an SFD
            if (!I_crs_dv) armed_q <= 1'b1;
            if (dibit_en) begin
                crc_q     <= crc_dibit(crc_q, I_rxd);
                dib_cnt_q <= dib_cnt_q + 2'd1;
                shift_q   <= {I_rxd, shift_q[5:2]};
            end
            if (byte_en) begin
                prev_q <= rx_byte;
                if (state_q != StDrop) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                StIdle: begin
                    if (armed_q && I_crs_dv && I_rxd == 2'b01) state_q <= StPreamble;
                end
                StPreamble: begin
                    if (I_crs_dv && I_rxd == 2'b11) begin
                        state_q     <= StDstMac;
                        O_busy      <= 1'b1;
                        dib_cnt_q   <= 2'd0;
                        frame_cnt_q <= 16'd0;
                        crc_q       <= 32'hFFFFFFFF;
                        uc_ok_q     <= 1'b1;
                        bc_ok_q     <= accept_bcast;
                    end else if (!(I_crs_dv && I_rxd == 2'b01)) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    if (frame_end) begin
                        state_q <= StIdle;
                        O_busy  <= 1'b0;
                        if (state_q == StTail || state_q == StPayload) begin
                            O_done   <= 1'b1;
                            O_crc_ok <= (state_q == StTail) && (crc_q == CrcResidue);
                        end else begin
                            O_drop <= 1'b1;
                        end
                    end else if (byte_en && state_q != StDrop) begin
                        if (hdr_fail || len_over) begin
                            state_q <= StDrop;
                        end else begin
                            case (state_q)
                                StDstMac: begin
                                    uc_ok_q <= uc_ok_d;
                                    bc_ok_q <= bc_ok_d;
                                    if (frame_cnt_q == 16'd5) state_q <= StSrcMac;
                                end
                                StSrcMac: if (frame_cnt_q == 16'd11) state_q <= StEtype;
                                StEtype:  if (frame_cnt_q == 16'd13) state_q <= StIpHdr;
                                StIpHdr:  if (frame_cnt_q == 16'd33) state_q <= StUdpHdr;
                                StUdpHdr: begin
                                    if (frame_cnt_q == 16'd39) O_udpLen <= hdr_word - 16'd8;
                                    if (frame_cnt_q == 16'd41) begin
                                        pay_cnt_q <= 16'd0;
                                        state_q   <= (O_udpLen == 16'd0) ? StTail : StPayload;
                                    end
                                end
                                StPayload: begin
                                    O_data    <= rx_byte;
                                    O_valid   <= 1'b1;
                                    O_sof     <= pay_cnt_q == 16'd0;
                                    O_eof     <= pay_cnt_q == O_udpLen - 16'd1;
                                    pay_cnt_q <= pay_cnt_q + 16'd1;
                                    if (pay_cnt_q == O_udpLen - 16'd1) state_q <= StTail;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rmii_rx.sv
// Bench for udp_rmii_rx: a table of frames run in a loop, then CRS_DV toggling and mid-frame
// reset sequences. Payload bytes are checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_udp_rmii_rx;
    localparam logic [47:0] MyMac  = 48'h02_12_34_56_78_9A;
    localparam logic [31:0] MyIp   = 32'hC0_A8_01_0A;
    localparam logic [15:0] MyPort = 16'd5005;

    logic        I_clk50m = 1'b0;
    logic        I_rst    = 1'b1;
    logic [1:0]  I_rxd    = 2'b00;
    logic        I_crs_dv = 1'b0;
    logic [7:0]  O_data;
    logic        O_valid;
    logic        O_sof;
    logic        O_eof;
    logic [15:0] O_udpLen;
    logic        O_done;
    logic        O_crc_ok;
    logic        O_drop;
    logic        O_busy;

    udp_rmii_rx #(
        .mac_my_adr  (MyMac),
        .ip_my_adr   (MyIp),
        .udp_my_port (MyPort),
        .accept_bcast(1'b1),
        .max_frame   (16'd1522)
    ) dut (
        .I_clk50m(I_clk50m),
        .I_rst   (I_rst),
        .I_rxd   (I_rxd),
        .I_crs_dv(I_crs_dv),
        .O_data  (O_data),
        .O_valid (O_valid),
        .O_sof   (O_sof),
        .O_eof   (O_eof),
        .O_udpLen(O_udpLen),
        .O_done  (O_done),
        .O_crc_ok(O_crc_ok),
        .O_drop  (O_drop),
        .O_busy  (O_busy)
    );

    always #10 I_clk50m = ~I_clk50m;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    typedef struct {
        string       name;
        logic [47:0] dst;
        logic [7:0]  proto;
        logic [15:0] port;
        logic [15:0] ulen;
        int          npay;
        int          npad;
        int          flip;
        int          trunc;
        bit          acc;
        bit          ok;
    } vec_t;

    exp_t       sb_q[$];
    logic [7:0] tx_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int evt_cyc = 0;
    int fall_cyc = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    bit chk_gap = 1'b1;

    always @(posedge I_clk50m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output monitor / scoreboard consumer, sampling on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge I_clk50m);
            if (O_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got data %02h sof %0b eof %0b expected none",
                             O_data, O_sof, O_eof);
                end else begin
                    e = sb_q.pop_front();
                    if ({O_data, O_sof, O_eof} !== e) begin
                        errors++;
                        $display("FAIL payload got %02h/%0b/%0b expected %02h/%0b/%0b",
                                 O_data, O_sof, O_eof, e.data, e.sof, e.eof);
                    end
                    if (chk_gap && !e.sof) check("valid_gap", 64'(cyc - last_valid_cyc), 64'd4);
                end
                last_valid_cyc = cyc;
            end
            if (O_done) begin
                done_cnt++;
                evt_cyc = cyc;
            end
            if (O_drop) begin
                drop_cnt++;
                evt_cyc = cyc;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] pay_byte(input int j);
        case (j)
            0:       return 8'hDE;
            1:       return 8'hAD;
            2:       return 8'hBE;
            3:       return 8'hEF;
            default: return 8'(j * 37 + 5);
        endcase
    endfunction

    task automatic push_n(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input vec_t v);
        logic [31:0] crc;
        tx_q.delete();
        push_n(64'(v.dst), 6);
        push_n(64'h02_00_00_00_00_07, 6);
        push_n(64'h0800, 2);
        push_n(64'h4500, 2);
        push_n(64'(v.ulen + 16'd20), 2);
        push_n(64'h0001_4000_40, 5);
        tx_q.push_back(v.proto);
        push_n(64'h0000, 2);
        push_n(64'hC0A8_0163, 4);
        push_n(64'(MyIp), 4);
        push_n(64'h04D2, 2);
        push_n(64'(v.port), 2);
        push_n(64'(v.ulen), 2);
        push_n(64'h0000, 2);
        for (int j = 0; j < v.npay; j++) tx_q.push_back(pay_byte(j));
        for (int j = 0; j < v.npad; j++) tx_q.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < tx_q.size(); i++) crc = crc_upd(crc, tx_q[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) tx_q.push_back(crc[8*i +: 8]);
        if (v.flip >= 0) tx_q[42 + v.flip] ^= 8'h01;
        if (v.trunc > 0) while (tx_q.size() > v.trunc) void'(tx_q.pop_back());
    endtask

    // Expected payload strobes for the bytes that actually reach the wire
    task automatic expect_payload(input vec_t v, input int sent);
        exp_t e;
        for (int j = 0; j < v.npay; j++) begin
            if (42 + j < sent) begin
                e.data = pay_byte(j) ^ ((j == v.flip) ? 8'h01 : 8'h00);
                e.sof  = (j == 0);
                e.eof  = (j == v.npay - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] d);
        @(negedge I_clk50m);
        I_crs_dv = dv;
        I_rxd    = d;
    endtask

    task automatic send_frame(input int toggle_at, input int rst_at);
        logic [7:0] v;
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int b = 0; b < tx_q.size(); b++) begin
            v = tx_q[b];
            for (int k = 0; k < 4; k++) begin
                if (b == toggle_at && k == 1) drive(1'b0, 2'b10);
                drive(1'b1, v[2*k +: 2]);
                if (b == 1 && k == 0) check("busy_in_frame", 64'(O_busy), 64'd1);
                if (b == rst_at && k == 0) I_rst = 1'b1;
                if (b == rst_at && k == 1)
                    check("outputs_after_rst",
                          {O_valid, O_sof, O_eof, O_done, O_drop, O_busy, O_crc_ok, O_data, O_udpLen},
                          64'd0);
                if (b == rst_at && k == 2) I_rst = 1'b0;
            end
        end
        drive(1'b0, 2'b00);
        fall_cyc = cyc;
        repeat (12) drive(1'b0, 2'b00);
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int p0;
        d0 = done_cnt;
        p0 = drop_cnt;
        build(v);
        if (v.acc) expect_payload(v, tx_q.size());
        send_frame(-1, -1);
        check({v.name, "_events"}, {32'(done_cnt - d0), 32'(drop_cnt - p0)},
              v.acc ? 64'h1_0000_0000 : 64'h1);
        check({v.name, "_evt_timing"}, 64'(evt_cyc), 64'(fall_cyc + 1));
        check({v.name, "_busy_low"}, 64'(O_busy), 64'd0);
        check({v.name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        if (v.acc) begin
            check({v.name, "_crc_ok"}, 64'(O_crc_ok), 64'(v.ok));
            check({v.name, "_udplen"}, 64'(O_udpLen), 64'(v.ulen - 16'd8));
        end
    endtask

    initial begin
        vec_t vecs[11];
        vec_t hv;
        int   d0;
        int   p0;
        vecs[0]  = '{"unicast",   MyMac,          8'h11, MyPort,        16'd12, 4,  0,  -1, 0,  1'b1, 1'b1};
        vecs[1]  = '{"bitflip",   MyMac,          8'h11, MyPort,        16'd12, 4,  0,  2,  0,  1'b1, 1'b0};
        vecs[2]  = '{"bcast",     48'hFFFFFFFFFFFF, 8'h11, MyPort,      16'd12, 4,  0,  -1, 0,  1'b1, 1'b1};
        vecs[3]  = '{"mac_off",   MyMac ^ 48'h1,  8'h11, MyPort,        16'd12, 4,  0,  -1, 0,  1'b0, 1'b0};
        vecs[4]  = '{"bad_port",  MyMac,          8'h11, MyPort + 16'd1, 16'd12, 4, 0,  -1, 0,  1'b0, 1'b0};
        vecs[5]  = '{"proto_tcp", MyMac,          8'h06, MyPort,        16'd12, 4,  0,  -1, 0,  1'b0, 1'b0};
        vecs[6]  = '{"len9_pad",  MyMac,          8'h11, MyPort,        16'd9,  1,  17, -1, 0,  1'b1, 1'b1};
        vecs[7]  = '{"trunc_hdr", MyMac,          8'h11, MyPort,        16'd12, 4,  0,  -1, 30, 1'b0, 1'b0};
        vecs[8]  = '{"len7",      MyMac,          8'h11, MyPort,        16'd7,  0,  18, -1, 0,  1'b0, 1'b0};
        vecs[9]  = '{"len8",      MyMac,          8'h11, MyPort,        16'd8,  0,  18, -1, 0,  1'b1, 1'b1};
        vecs[10] = '{"trunc_pay", MyMac,          8'h11, MyPort,        16'd20, 12, 0,  -1, 47, 1'b1, 1'b0};

        repeat (3) @(negedge I_clk50m);
        check("reset_outputs",
              {O_valid, O_sof, O_eof, O_done, O_drop, O_busy, O_crc_ok, O_data, O_udpLen}, 64'd0);
        I_rst = 1'b0;
        repeat (4) @(negedge I_clk50m);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // CRS_DV dips low between dibits mid-payload; bytes must survive
        hv = '{"toggle", MyMac, 8'h11, MyPort, 16'd16, 8, 0, -1, 0, 1'b1, 1'b1};
        d0 = done_cnt;
        build(hv);
        expect_payload(hv, tx_q.size());
        chk_gap = 1'b0;
        send_frame(44, -1);
        chk_gap = 1'b1;
        check("toggle_done", 64'(done_cnt - d0), 64'd1);
        check("toggle_crc_ok", 64'(O_crc_ok), 64'd1);
        check("toggle_sb_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();

        // Reset pulsed mid-payload: only bytes finished before reset appear, no completion
        hv = '{"rst", MyMac, 8'h11, MyPort, 16'd20, 12, 0, -1, 0, 1'b1, 1'b1};
        d0 = done_cnt;
        p0 = drop_cnt;
        build(hv);
        expect_payload(hv, 46);
        send_frame(-1, 46);
        check("rst_events", {32'(done_cnt - d0), 32'(drop_cnt - p0)}, 64'd0);
        check("rst_sb_empty", 64'(sb_q.size()), 64'd0);
        check("rst_busy_low", 64'(O_busy), 64'd0);
        sb_q.delete();

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
